// File: rtl/fp_cmp_pkg.sv
// Shared constants for the FloPoCo-format comparator: exception and mode codes,
// operand width helper and the canonical NaN pattern.
package fp_cmp_pkg;

    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    localparam logic [2:0] MODE_GT = 3'd0;
    localparam logic [2:0] MODE_GE = 3'd1;
    localparam logic [2:0] MODE_LT = 3'd2;
    localparam logic [2:0] MODE_LE = 3'd3;
    localparam logic [2:0] MODE_EQ = 3'd4;
    localparam logic [2:0] MODE_NE = 3'd5;

    // Canonical NaN left-aligned; take the top W bits for an operand of width W.
    localparam logic [63:0] CANON_NAN_MSB = {EXC_NAN, 62'd0};

    function automatic int fp_width(input int we, input int wf);
        return we + wf + 3;
    endfunction

endpackage

// File: rtl/fp_cmp_classify.sv
// Combinational operand classifier: NaN/zero flags plus a signed ordering key
// whose integer order matches the floating-point order of non-NaN operands.
module fp_cmp_classify
    import fp_cmp_pkg::*;
#(
    parameter int WE = 11,
    parameter int WF = 2
) (
    input  logic [WE+WF+2:0]        op_i,
    output logic                    nan_o,
    output logic                    zero_o,
    output logic signed [WE+WF+1:0] key_o
);

    localparam int W  = fp_width(WE, WF);
    localparam int MW = WE + WF + 1;

    logic [1:0]    exc;
    logic          sign;
    logic [MW-1:0] mag;

    assign exc  = op_i[W-1:W-2];
    assign sign = op_i[W-3];

    // Normals sit strictly between zero (0) and infinity (all ones).
    always_comb begin
        mag = '0;
        case (exc)
            EXC_NORM: mag = {1'b0, op_i[WE+WF-1:0]} + MW'(1);
            EXC_INF:  mag = '1;
            default:  mag = '0;
        endcase
    end

    assign nan_o  = (exc == EXC_NAN);
    assign zero_o = (exc == EXC_ZERO);
    assign key_o  = sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

endmodule

// File: rtl/fp_compare_pipe.sv
// Pipelined FloPoCo comparator with valid/ready backpressure, tag pass-through
// and NaN-aware results. Optional min/max outputs under FP_CMP_MINMAX_EN.
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int WE   = 11,
    parameter int WF   = 2,
    parameter int LAT  = 2,
    parameter int TAGW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WE+WF+2:0]    in_a,
    input  logic [WE+WF+2:0]    in_b,
    input  logic [2:0]          in_mode,
    input  logic [TAGW-1:0]     in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_result,
    output logic                out_unord,
`ifdef FP_CMP_MINMAX_EN
    output logic [WE+WF+2:0]    out_min,
    output logic [WE+WF+2:0]    out_max,
`endif
    output logic [TAGW-1:0]     out_tag
);

    localparam int W  = fp_width(WE, WF);
    localparam int KW = WE + WF + 2;

    typedef struct packed {
        logic [KW-1:0]   ka;
        logic [KW-1:0]   kb;
        logic            zab;
        logic            unord;
        logic [2:0]      mode;
        logic [TAGW-1:0] tag;
`ifdef FP_CMP_MINMAX_EN
        logic [W-1:0]    a;
        logic [W-1:0]    b;
`endif
    } kpay_t;

    function automatic logic mode_result(input logic [2:0] mode, input logic gt,
                                         input logic eq, input logic unord);
        logic r;
        if (unord) begin
            r = (mode == MODE_NE);
        end else begin
            case (mode)
                MODE_GT: r = gt;
                MODE_GE: r = gt | eq;
                MODE_LT: r = !gt && !eq;
                MODE_LE: r = !gt;
                MODE_EQ: r = eq;
                MODE_NE: r = !eq;
                default: r = gt;
            endcase
        end
        return r;
    endfunction

    logic signed [KW-1:0] key_a, key_b;
    logic                 nan_a, nan_b, zero_a, zero_b;
    kpay_t                pay_in;
    kpay_t                pay_last;
    logic                 vld_last;
    logic                 en_out;

    fp_cmp_classify #(.WE(WE), .WF(WF)) u_cls_a (
        .op_i(in_a), .nan_o(nan_a), .zero_o(zero_a), .key_o(key_a)
    );
    fp_cmp_classify #(.WE(WE), .WF(WF)) u_cls_b (
        .op_i(in_b), .nan_o(nan_b), .zero_o(zero_b), .key_o(key_b)
    );

    always_comb begin
        pay_in       = '0;
        pay_in.ka    = key_a;
        pay_in.kb    = key_b;
        pay_in.zab   = zero_a & zero_b;
        pay_in.unord = nan_a | nan_b;
        pay_in.mode  = in_mode;
        pay_in.tag   = in_tag;
`ifdef FP_CMP_MINMAX_EN
        pay_in.a     = in_a;
        pay_in.b     = in_b;
`endif
    end

    logic out_valid_q;
    assign en_out = !out_valid_q || out_ready;

    generate
        if (LAT == 1) begin : g_direct
            assign pay_last = pay_in;
            assign vld_last = in_valid;
            assign in_ready = en_out;
        end else begin : g_stages
            localparam int NK = LAT - 1;

            kpay_t         pay_q  [NK];
            kpay_t         pchain [NK];
            logic [NK-1:0] vld_q;
            logic [NK:0]   vchain;
            logic [NK-1:0] en;

            assign vchain = {vld_q, in_valid};

            // A stage may load when it is empty or everything downstream of it can move.
            always_comb begin
                logic full;
                en = '0;
                for (int k = 0; k < NK; k++) begin
                    full = 1'b1;
                    for (int j = k; j < NK; j++) full = full & vld_q[j];
                    en[k] = !full || en_out;
                end
            end

            always_comb begin
                pchain[0] = pay_in;
                for (int k = 1; k < NK; k++) pchain[k] = pay_q[k-1];
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_q <= '0;
                end else begin
                    for (int k = 0; k < NK; k++)
                        if (en[k]) vld_q[k] <= vchain[k];
                end
            end

            always_ff @(posedge clk) begin
                for (int k = 0; k < NK; k++)
                    if (en[k] && vchain[k]) pay_q[k] <= pchain[k];
            end

            assign pay_last = pay_q[NK-1];
            assign vld_last = vld_q[NK-1];
            assign in_ready = en[0];
        end
    endgenerate

    // Last stage: compare keys and select the mode result.
    logic gt_d, eq_d, result_d;
    logic out_result_q, out_unord_q;
    logic [TAGW-1:0] out_tag_q;

    assign gt_d     = $signed(pay_last.ka) > $signed(pay_last.kb);
    assign eq_d     = pay_last.zab || (pay_last.ka == pay_last.kb);
    assign result_d = mode_result(pay_last.mode, gt_d, eq_d, pay_last.unord);

`ifdef FP_CMP_MINMAX_EN
    localparam logic [W-1:0] CANON_NAN = CANON_NAN_MSB[63 -: W];
    logic [W-1:0] min_d, max_d, out_min_q, out_max_q;

    always_comb begin
        if (pay_last.unord) begin
            min_d = CANON_NAN;
            max_d = CANON_NAN;
        end else if (gt_d) begin
            min_d = pay_last.b;
            max_d = pay_last.a;
        end else begin
            min_d = pay_last.a;
            max_d = pay_last.b;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 1'b0;
            out_unord_q  <= 1'b0;
            out_tag_q    <= '0;
`ifdef FP_CMP_MINMAX_EN
            out_min_q    <= '0;
            out_max_q    <= '0;
`endif
        end else if (en_out) begin
            out_valid_q <= vld_last;
            if (vld_last) begin
                out_result_q <= result_d;
                out_unord_q  <= pay_last.unord;
                out_tag_q    <= pay_last.tag;
`ifdef FP_CMP_MINMAX_EN
                out_min_q    <= min_d;
                out_max_q    <= max_d;
`endif
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_unord  = out_unord_q;
    assign out_tag    = out_tag_q;
`ifdef FP_CMP_MINMAX_EN
    assign out_min    = out_min_q;
    assign out_max    = out_max_q;
`endif

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed bench for fp_compare_pipe (WE=11, WF=2, LAT=2): modes, signed zero,
// infinities, NaN, backpressure ordering and asynchronous mid-flight reset.
module tb_fp_compare_pipe;
    localparam int WE   = 11;
    localparam int WF   = 2;
    localparam int LAT  = 2;
    localparam int TAGW = 4;
    localparam int W    = WE + WF + 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, out_valid, out_ready, out_result, out_unord;
    logic [W-1:0]    in_a, in_b;
    logic [2:0]      in_mode;
    logic [TAGW-1:0] in_tag, out_tag;
`ifdef FP_CMP_MINMAX_EN
    logic [W-1:0]    out_min, out_max;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_compare_pipe #(.WE(WE), .WF(WF), .LAT(LAT), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_unord(out_unord),
`ifdef FP_CMP_MINMAX_EN
        .out_min(out_min), .out_max(out_max),
`endif
        .out_tag(out_tag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated transaction: accepted at the first posedge, result LAT cycles later.
    task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] m, input logic [TAGW-1:0] t,
                          input logic er, input logic eu);
        @(negedge clk);
        in_a = a; in_b = b; in_mode = m; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            chk({tag, "_early"}, 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, 32'(out_result), 32'(er));
        chk({tag, "_unord"}, 32'(out_unord), 32'(eu));
        chk({tag, "_tag"}, 32'(out_tag), 32'(t));
    endtask

    logic [W-1:0]    bp_a   [6] = '{16'h5000, 16'h4FFC, 16'h0000, 16'h6FFC, 16'h8000, 16'hC000};
    logic [W-1:0]    bp_b   [6] = '{16'h4FFC, 16'h5000, 16'h2000, 16'h4FFD, 16'h5000, 16'h4FFC};
    logic [2:0]      bp_m   [6] = '{3'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd5};
    logic            bp_res [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic            bp_un  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int              pushed, popped;
        logic            stalled, saw_nready, prev_res, prev_un;
        logic [TAGW-1:0] prev_tag;

        in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0; in_mode = '0; in_tag = '0;
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(out_result), 32'd0);
        chk("rst_unord", 32'(out_unord), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        single("gt_2_1",     16'h5000, 16'h4FFC, 3'd0, 4'd3, 1'b1, 1'b0);
        single("lt_2_1",     16'h5000, 16'h4FFC, 3'd2, 4'd1, 1'b0, 1'b0);
        single("eq_pz_nz",   16'h0000, 16'h2000, 3'd4, 4'd2, 1'b1, 1'b0);
        single("gt_pz_nz",   16'h0000, 16'h2000, 3'd0, 4'd4, 1'b0, 1'b0);
        single("ge_pz_nz",   16'h0000, 16'h2000, 3'd1, 4'd5, 1'b1, 1'b0);
        single("lt_neg",     16'h6FFC, 16'h4FFD, 3'd2, 4'd6, 1'b1, 1'b0);
        single("gt_inf",     16'h8000, 16'h5000, 3'd0, 4'd7, 1'b1, 1'b0);
        single("lt_ninf",    16'hA000, 16'h6FFC, 3'd2, 4'd8, 1'b1, 1'b0);
        single("lt_negmag",  16'h6FFD, 16'h6FFC, 3'd2, 4'd9, 1'b1, 1'b0);
        single("le_eq",      16'h4FFD, 16'h4FFD, 3'd3, 4'd10, 1'b1, 1'b0);
        single("mode6_gt",   16'h5000, 16'h4FFC, 3'd6, 4'd11, 1'b1, 1'b0);
        single("mode7_gt",   16'h4FFC, 16'h5000, 3'd7, 4'd12, 1'b0, 1'b0);
        single("nan_gt",     16'hC000, 16'h4FFC, 3'd0, 4'd1, 1'b0, 1'b1);
        single("nan_ge",     16'hC000, 16'h4FFC, 3'd1, 4'd2, 1'b0, 1'b1);
        single("nan_lt",     16'hC000, 16'h4FFC, 3'd2, 4'd3, 1'b0, 1'b1);
        single("nan_le",     16'hC000, 16'h4FFC, 3'd3, 4'd4, 1'b0, 1'b1);
        single("nan_eq",     16'hC000, 16'h4FFC, 3'd4, 4'd5, 1'b0, 1'b1);
        single("nan_ne",     16'hC000, 16'h4FFC, 3'd5, 4'd6, 1'b1, 1'b1);
        single("ne_diff",    16'h5000, 16'h4FFC, 3'd5, 4'd7, 1'b1, 1'b0);

        pushed = 0; popped = 0; stalled = 1'b0; saw_nready = 1'b0;
        prev_res = 1'b0; prev_un = 1'b0; prev_tag = '0;
        for (int cyc = 0; cyc < 40 && popped < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (pushed < 6) begin
                in_valid = 1'b1;
                in_a = bp_a[pushed]; in_b = bp_b[pushed];
                in_mode = bp_m[pushed]; in_tag = TAGW'(8 + pushed);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                chk("bp_hold_vld", 32'(out_valid), 32'd1);
                chk("bp_hold_tag", 32'(out_tag), 32'(prev_tag));
                chk("bp_hold_res", 32'(out_result), 32'(prev_res));
                chk("bp_hold_unord", 32'(out_unord), 32'(prev_un));
            end
            if (in_valid && !in_ready) saw_nready = 1'b1;
            if (out_valid && out_ready) begin
                chk("bp_tag", 32'(out_tag), 32'(8 + popped));
                chk("bp_res", 32'(out_result), 32'(bp_res[popped]));
                chk("bp_unord", 32'(out_unord), 32'(bp_un[popped]));
                popped++;
            end
            stalled  = out_valid && !out_ready;
            prev_tag = out_tag; prev_res = out_result; prev_un = out_unord;
            if (in_valid && in_ready) pushed++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_popped", 32'(popped), 32'd6);
        chk("bp_nready_seen", 32'(saw_nready), 32'd1);
        repeat (2) @(negedge clk);
        chk("bp_no_dup", 32'(out_valid), 32'd0);

        @(negedge clk);
        in_a = 16'h5000; in_b = 16'h4FFC; in_mode = 3'd0; in_tag = 4'd5; in_valid = 1'b1;
        @(negedge clk);
        in_tag = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_vld", 32'(out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(out_valid), 32'd0);
        chk("mid_rst_tag", 32'(out_tag), 32'd0);
        chk("mid_rst_res", 32'(out_result), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'(out_valid), 32'd0);
        end
        single("post_rst", 16'h4FFC, 16'h5000, 3'd2, 4'd7, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
